// File: rtl/delayed_sync_tracker_if.sv
// Bundle between the MMIO commit point, the delayed-register return paths and
// the tracker. The core side drives through master, the tracker uses slave.
interface delayed_sync_tracker_if #(
  parameter int unsigned NUM_CH = 4
) ();
  localparam int unsigned ID_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              wenable;
  logic              isMMIO;
  logic              isdelayed;
  logic              instr_exed;
  logic [ID_W-1:0]   issue_ch;
  logic [NUM_CH-1:0] delayed_valid;
  logic              err_clr;
  logic              syn_reg_update;
  logic [NUM_CH-1:0] syn_reg_update_ch;
  logic              issue_stall;
  logic [NUM_CH-1:0] sync_valid;
  logic [NUM_CH-1:0] pend_busy;
  logic [NUM_CH-1:0] overflow_err;
  logic [NUM_CH-1:0] timeout_err;

  modport master (
    output wenable, isMMIO, isdelayed, instr_exed, issue_ch, delayed_valid, err_clr,
    input  syn_reg_update, syn_reg_update_ch, issue_stall, sync_valid, pend_busy,
           overflow_err, timeout_err
  );

  modport slave (
    input  wenable, isMMIO, isdelayed, instr_exed, issue_ch, delayed_valid, err_clr,
    output syn_reg_update, syn_reg_update_ch, issue_stall, sync_valid, pend_busy,
           overflow_err, timeout_err
  );
endinterface

// File: rtl/delayed_sync_tracker.sv
// Per-channel tracker of outstanding delayed MMIO register writes. A channel's
// delayed-register return is forwarded as sync_valid only while that channel
// has writes outstanding. Full channels reject issues (sticky overflow), and a
// busy channel without progress for TIMEOUT cycles raises a sticky timeout.
module delayed_sync_tracker #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned MAX_PEND = 4,
  parameter int unsigned TIMEOUT  = 1024
) (
  input logic                   clk,
  input logic                   resetn,
  delayed_sync_tracker_if.slave bus
);
  localparam int unsigned ID_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_PEND + 1);
  localparam int unsigned TO_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PEND);
  localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(TIMEOUT);

  logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_CH-1:0][TO_W-1:0]  age_q, age_d;
  logic [NUM_CH-1:0]            ovf_q, ovf_d;
  logic [NUM_CH-1:0]            to_q, to_d;

  logic              issue;
  logic              stall;
  logic [NUM_CH-1:0] busy, full, hit, acc, sv;

  // Issue decode and return gating; stall depends only on issue_ch and counters.
  always_comb begin
    issue = bus.wenable & bus.isMMIO & bus.isdelayed & bus.instr_exed;
    stall = 1'b0;
    busy  = '0;
    full  = '0;
    hit   = '0;
    acc   = '0;
    sv    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      busy[i] = (cnt_q[i] != '0);
      full[i] = (cnt_q[i] == CNT_MAX);
      hit[i]  = issue & (bus.issue_ch == ID_W'(i));
      acc[i]  = hit[i] & ~full[i];
      sv[i]   = bus.delayed_valid[i] & busy[i];
      if (bus.issue_ch == ID_W'(i)) begin
        stall = full[i];
      end
    end
  end

  // Next-state for pending counts, stall ages and sticky error flags.
  always_comb begin
    cnt_d = cnt_q;
    age_d = '0;
    ovf_d = '0;
    to_d  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      case ({acc[i], sv[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + CNT_W'(1);
        2'b01:   cnt_d[i] = cnt_q[i] - CNT_W'(1);
        default: cnt_d[i] = cnt_q[i];
      endcase
      // Age only counts busy cycles with no completion; it saturates at TO_MAX.
      if ((TIMEOUT != 0) && busy[i] && !sv[i]) begin
        age_d[i] = (age_q[i] == TO_MAX) ? age_q[i] : age_q[i] + TO_W'(1);
      end
      // A new event in the same cycle as err_clr keeps the flag set.
      ovf_d[i] = (ovf_q[i] & ~bus.err_clr) | (hit[i] & full[i]);
      to_d[i]  = (to_q[i] & ~bus.err_clr) | ((age_d[i] == TO_MAX) & (age_q[i] != TO_MAX));
    end
  end

  // State registers; reset discards all outstanding writes and errors.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
      age_q <= '0;
      ovf_q <= '0;
      to_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      age_q <= age_d;
      ovf_q <= ovf_d;
      to_q  <= to_d;
    end
  end

  assign bus.syn_reg_update    = issue;
  assign bus.syn_reg_update_ch = acc & {NUM_CH{resetn}};
  assign bus.issue_stall       = stall;
  assign bus.sync_valid        = sv;
  assign bus.pend_busy         = busy;
  assign bus.overflow_err      = ovf_q;
  assign bus.timeout_err       = to_q;
endmodule

// File: tb/tb_delayed_sync_tracker.sv
// Bench for delayed_sync_tracker: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a counting model.
module tb_delayed_sync_tracker;
  localparam int NCH = 4;
  localparam int MP  = 4;
  localparam int TO  = 8;

  logic clk;
  logic resetn;
  logic rst_seen;
  int   n_chk;
  int   n_fail;

  // Behavioural model: outstanding count and busy cycles since last progress.
  int m_cnt   [NCH];
  int m_since [NCH];
  bit m_ovf   [NCH];
  bit m_to    [NCH];

  delayed_sync_tracker_if #(.NUM_CH(NCH)) bus ();

  delayed_sync_tracker #(
    .NUM_CH  (NCH),
    .MAX_PEND(MP),
    .TIMEOUT (TO)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic iss, input logic [1:0] ch, input logic [3:0] dv,
                        input logic clr);
    bus.wenable       = iss;
    bus.isMMIO        = iss;
    bus.isdelayed     = iss;
    bus.instr_exed    = iss;
    bus.issue_ch      = ch;
    bus.delayed_valid = dv;
    bus.err_clr       = clr;
  endtask

  // Advance to the next cycle, drive its inputs, let comb outputs settle.
  task automatic go(input logic iss, input logic [1:0] ch, input logic [3:0] dv,
                    input logic clr);
    @(posedge clk);
    #1;
    set_in(iss, ch, dv, clr);
    #1;
  endtask

  initial begin
    rst_seen = 1'b0;
    forever begin
      @(negedge resetn);
      rst_seen = 1'b1;
    end
  end

  // Compare process: check every output mid-cycle, then advance the model.
  initial begin
    logic       issue;
    logic       e_stall;
    logic [3:0] e_acc, e_sv, e_busy, e_ovf, e_to;
    bit         hit, evt;
    forever begin
      @(negedge clk);
      if (rst_seen || !resetn) begin
        for (int i = 0; i < NCH; i++) begin
          m_cnt[i] = 0; m_since[i] = 0; m_ovf[i] = 0; m_to[i] = 0;
        end
        rst_seen = 1'b0;
      end
      issue   = bus.wenable & bus.isMMIO & bus.isdelayed & bus.instr_exed;
      e_stall = 1'b0;
      for (int i = 0; i < NCH; i++) begin
        e_busy[i] = (m_cnt[i] > 0);
        e_acc[i]  = issue && (bus.issue_ch == i) && (m_cnt[i] < MP) && resetn;
        e_sv[i]   = bus.delayed_valid[i] && (m_cnt[i] > 0);
        e_ovf[i]  = m_ovf[i];
        e_to[i]   = m_to[i];
        if ((bus.issue_ch == i) && (m_cnt[i] == MP)) e_stall = 1'b1;
      end
      chk("cmp_syn_reg_update", bus.syn_reg_update, issue);
      chk("cmp_syn_reg_update_ch", bus.syn_reg_update_ch, e_acc);
      chk("cmp_issue_stall", bus.issue_stall, e_stall);
      chk("cmp_sync_valid", bus.sync_valid, e_sv);
      chk("cmp_pend_busy", bus.pend_busy, e_busy);
      chk("cmp_overflow_err", bus.overflow_err, e_ovf);
      chk("cmp_timeout_err", bus.timeout_err, e_to);
      if (resetn) begin
        for (int i = 0; i < NCH; i++) begin
          hit = issue && (bus.issue_ch == i);
          m_ovf[i] = (hit && (m_cnt[i] == MP)) || (m_ovf[i] && !bus.err_clr);
          evt = 1'b0;
          if (e_sv[i] || !e_busy[i]) begin
            m_since[i] = 0;
          end else begin
            m_since[i]++;
            evt = (m_since[i] == TO);
          end
          m_to[i]  = evt || (m_to[i] && !bus.err_clr);
          m_cnt[i] = m_cnt[i] + int'(e_acc[i]) - int'(e_sv[i]);
        end
      end
    end
  end

  initial begin
    int pi, pd, q;
    n_chk  = 0;
    n_fail = 0;
    resetn = 1'b1;
    set_in(0, 0, 4'h0, 0);
    #1;
    resetn = 1'b0;
    set_in(1, 0, 4'hF, 0);
    #1;
    chk("rst_srch", bus.syn_reg_update_ch, 4'h0);
    chk("rst_sru", bus.syn_reg_update, 1'b1);
    chk("rst_busy", bus.pend_busy, 4'h0);
    chk("rst_sv", bus.sync_valid, 4'h0);
    chk("rst_stall", bus.issue_stall, 1'b0);
    go(0, 0, 4'h0, 0);
    go(0, 0, 4'h0, 0);
    resetn = 1'b1;

    // Single round trip on ch2.
    go(1, 2, 4'b0100, 0);
    chk("rt_t0_sv", bus.sync_valid, 4'h0);
    chk("rt_t0_acc", bus.syn_reg_update_ch, 4'b0100);
    go(0, 0, 4'h0, 0);
    chk("rt_t1_busy", bus.pend_busy, 4'b0100);
    go(0, 0, 4'h0, 0);
    go(0, 0, 4'b0100, 0);
    chk("rt_t3_sv", bus.sync_valid, 4'b0100);
    go(0, 0, 4'h0, 0);
    chk("rt_t4_busy", bus.pend_busy, 4'h0);

    // Fill ch1 and overflow it.
    for (int k = 0; k < 4; k++) begin
      go(1, 1, 4'h0, 0);
      chk("fill_stall", bus.issue_stall, 1'b0);
    end
    go(1, 1, 4'h0, 0);
    chk("fill_stall5", bus.issue_stall, 1'b1);
    chk("fill_rej", bus.syn_reg_update_ch, 4'h0);
    go(0, 1, 4'h0, 0);
    chk("ovf_set", bus.overflow_err, 4'b0010);
    chk("ovf_cnt4", bus.issue_stall, 1'b1);
    for (int k = 0; k < 4; k++) begin
      go(0, 1, 4'b0010, 0);
      chk("drain_sv", bus.sync_valid, 4'b0010);
    end
    go(0, 0, 4'h0, 1);
    chk("drain_idle", bus.pend_busy, 4'h0);
    go(0, 0, 4'h0, 0);
    chk("ovf_clr", bus.overflow_err, 4'h0);

    // Simultaneous issue and completion on ch0.
    go(1, 0, 4'h0, 0);
    go(1, 0, 4'h0, 0);
    go(1, 0, 4'b0001, 0);
    chk("sim_sv", bus.sync_valid, 4'b0001);
    chk("sim_acc", bus.syn_reg_update_ch, 4'b0001);
    go(1, 0, 4'h0, 0);
    go(1, 0, 4'h0, 0);
    go(1, 0, 4'b0001, 0);
    chk("sim_full_stall", bus.issue_stall, 1'b1);
    chk("sim_full_sv", bus.sync_valid, 4'b0001);
    chk("sim_full_acc", bus.syn_reg_update_ch, 4'h0);
    go(0, 0, 4'b0001, 0);
    chk("sim_ovf", bus.overflow_err, 4'b0001);
    chk("sim_cnt3", bus.issue_stall, 1'b0);
    go(0, 0, 4'b0001, 0);
    go(0, 0, 4'b0001, 0);
    go(0, 0, 4'h0, 1);
    chk("sim_idle", bus.pend_busy, 4'h0);

    // Timeout on ch3, then err_clr and set-wins.
    go(1, 3, 4'h0, 0);
    for (int k = 1; k <= 8; k++) begin
      go(0, 3, 4'h0, 0);
      chk("to_early", bus.timeout_err, 4'h0);
    end
    go(0, 3, 4'b1000, 0);
    chk("to_set", bus.timeout_err, 4'b1000);
    chk("to_late_sv", bus.sync_valid, 4'b1000);
    go(0, 0, 4'h0, 1);
    chk("to_sticky", bus.timeout_err, 4'b1000);
    chk("to_idle", bus.pend_busy, 4'h0);
    go(0, 0, 4'h0, 0);
    chk("to_clr", bus.timeout_err, 4'h0);
    go(1, 3, 4'h0, 0);
    for (int k = 1; k <= 7; k++) go(0, 3, 4'h0, 0);
    go(0, 3, 4'h0, 1);
    go(0, 3, 4'h0, 1);
    chk("to_set_wins", bus.timeout_err, 4'b1000);
    go(0, 3, 4'b1000, 0);
    chk("to_clr2", bus.timeout_err, 4'h0);
    chk("to_clr2_sv", bus.sync_valid, 4'b1000);
    go(0, 0, 4'h0, 0);

    // Spurious returns on idle channels.
    go(0, 0, 4'hF, 0);
    chk("spur_sv", bus.sync_valid, 4'h0);
    go(0, 0, 4'h0, 0);
    chk("spur_busy", bus.pend_busy, 4'h0);

    // Asynchronous reset with ch0 and ch2 busy.
    go(1, 0, 4'h0, 0);
    go(1, 2, 4'h0, 0);
    go(0, 0, 4'h0, 0);
    chk("pre_rst_busy", bus.pend_busy, 4'b0101);
    go(0, 0, 4'b0101, 0);
    chk("pre_rst_sv", bus.sync_valid, 4'b0101);
    resetn = 1'b0;
    #1;
    chk("rst_busy_now", bus.pend_busy, 4'h0);
    chk("rst_sv_now", bus.sync_valid, 4'h0);
    resetn = 1'b1;
    #1;
    chk("post_rst_sv", bus.sync_valid, 4'h0);
    go(0, 0, 4'b0101, 0);
    chk("post_rst_sv2", bus.sync_valid, 4'h0);
    go(1, 0, 4'h0, 0);
    chk("post_rst_acc", bus.syn_reg_update_ch, 4'b0001);
    go(0, 0, 4'h0, 0);
    chk("post_rst_busy", bus.pend_busy, 4'b0001);
    go(0, 0, 4'b0001, 0);
    chk("post_rst_ret", bus.sync_valid, 4'b0001);

    // Randomized traffic in issue-heavy, return-heavy and balanced phases.
    for (int k = 0; k < 600; k++) begin
      case ((k / 40) % 3)
        0:       begin pi = 70; pd = 10; end
        1:       begin pi = 15; pd = 60; end
        default: begin pi = 40; pd = 35; end
      endcase
      @(posedge clk);
      #1;
      q = ($urandom_range(0, 99) < pi) ? 15 : $urandom_range(0, 14);
      bus.wenable    = q[0];
      bus.isMMIO     = q[1];
      bus.isdelayed  = q[2];
      bus.instr_exed = q[3];
      bus.issue_ch   = 2'($urandom_range(0, NCH - 1));
      for (int i = 0; i < NCH; i++) bus.delayed_valid[i] = ($urandom_range(0, 99) < pd);
      bus.err_clr = ($urandom_range(0, 99) < 4);
    end
    go(0, 0, 4'h0, 0);
    @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/delayed_sync_tracker.md
# delayed_sync_tracker

Multi-channel successor to the single-flag delayed-MMIO-write synchroniser. The block sits between the core's MMIO write-commit point and the delayed-register return paths. It counts outstanding delayed register writes per channel and passes a channel's delayed-valid return to `sync_valid` only while that channel has a write outstanding. It adds the following:
- per-channel pending depth with back-pressure;
- overflow detection;
- a programmable stall timeout with sticky error flags.

## Interface
Parameters:
- `NUM_CH`, 4: number of independent delayed-register channels (≥1).
- `MAX_PEND`, 4: maximum outstanding delayed writes per channel (≥1).
- `TIMEOUT`, 1024: cycles without progress on a busy channel before `timeout_err` sets; 0 disables the timeout.
- Derived: `ID_W` = max(1, clog2(`NUM_CH`)); `CNT_W` = clog2(`MAX_PEND`+1); `TO_W` = max(1, clog2(`TIMEOUT`+1)).

Ports:
- `clk`  in  1  single clock, rising edge.
- `resetn`  in  1  reset, asynchronous, active-low.
- `wenable`  in  1  write-enable qualifier of the committing instruction.
- `isMMIO`  in  1  target is MMIO.
- `isdelayed`  in  1  target register is delayed-update.
- `instr_exed`  in  1  instruction executed this cycle.
- `issue_ch`  in  `ID_W`  channel addressed by the write.
- `delayed_valid`  in  `NUM_CH`  per-channel delayed-register return strobe.
- `err_clr`  in  1  clears all sticky error flags.
- `syn_reg_update`  out  1  `wenable & isMMIO & isdelayed & instr_exed` (combinational).
- `syn_reg_update_ch`  out  `NUM_CH`  one-hot accepted issue (combinational).
- `issue_stall`  out  1  addressed channel is full (combinational from `issue_ch` and the counters).
- `sync_valid`  out  `NUM_CH`  `delayed_valid[i] & (pend_cnt[i] != 0)` (combinational).
- `pend_busy`  out  `NUM_CH`  `pend_cnt[i] != 0`, taken from registered state.
- `overflow_err`  out  `NUM_CH`  sticky: an issue arrived while the channel was full.
- `timeout_err`  out  `NUM_CH`  sticky: the channel timed out.

## Operation
Issue decode:
- `issue` = `syn_reg_update`.
- `issue_ch` ≥ `NUM_CH`: the issue is ignored and no error is flagged.
- Channel i sees `hit[i]` = `issue & (issue_ch == i)`.
- `full[i]` = (`pend_cnt[i] == MAX_PEND`).
- Accepted issue: `acc[i]` = `hit[i] & ~full[i]`.
- `syn_reg_update_ch[i]` = `acc[i]`.
- `hit[i] & full[i]` sets `overflow_err[i]`; the count is unchanged and the write is dropped.

Completion:
- `sync_valid[i]` = `delayed_valid[i] & pend_busy[i]`.
- `delayed_valid` on an idle channel is ignored: no pulse and no count change.

Counter `pend_cnt[i]`, range 0..`MAX_PEND`, updated each edge:
- `acc` only: +1.
- `sync_valid` only: −1.
- `acc` and `sync_valid` together: unchanged.
- Neither: hold.
- `full` is evaluated on the pre-edge count. An issue to a full channel is rejected even if a completion on that channel occurs in the same cycle.

Timeout, when `TIMEOUT` > 0, per channel `age[i]` (`TO_W` bits):
- Cleared to 0 on `acc[i]` when `pend_cnt` is 0.
- Cleared to 0 on any `sync_valid[i]`.
- Cleared to 0 whenever `pend_cnt[i]` is 0.
- Otherwise increments while busy, saturating at `TIMEOUT`.
- `age[i]` reaching `TIMEOUT` sets `timeout_err[i]`. The pending count is retained and no flush occurs.

Error flags:
- `err_clr` clears all sticky flags at the next edge.
- If a new error event occurs in the same cycle as `err_clr`, the set wins.

Reset:
- `resetn` low asynchronously forces all `pend_cnt`, `age`, `overflow_err` and `timeout_err` to 0.
- Consequently, during reset and immediately after it: `pend_busy` = 0, `sync_valid` = 0, `issue_stall` = 0, `syn_reg_update_ch` = 0.
- `syn_reg_update` follows its inputs during reset.
- Reset mid-operation discards all outstanding writes. Returns arriving after reset produce no `sync_valid`.

## Timing
- `syn_reg_update`, `syn_reg_update_ch`, `issue_stall` and `sync_valid` are zero-latency combinational outputs.
- An issue accepted at edge-cycle t makes `pend_busy` = 1 from cycle t+1. The earliest `sync_valid` for that write is at t+1.
- `delayed_valid` in the same cycle as the first issue to an idle channel yields no pulse.
- A completion at cycle t clears `pend_busy` at t+1 if the count was 1.
- Timeout: with the last progress at edge e, `timeout_err` is visible `TIMEOUT` cycles later (±0). The error is registered.
- Sticky flags rise one cycle after the causing event.
- No combinational path from `delayed_valid` to `issue_stall`.

## Test plan
- **Single round trip:** issue ch2 at t0, `delayed_valid[2]` at t0 and again at t3 → no pulse at t0; `sync_valid[2]` = 1 at t3 only; `pend_busy[2]` falls at t4.
- **Fill and overflow:** `MAX_PEND`=4, five issues to ch1 with no returns → `issue_stall` = 1 before the 5th; `overflow_err[1]` = 1 the cycle after; count stays 4; four returns give four `sync_valid` pulses.
- **Simultaneous events:** ch0 count 2, issue plus `delayed_valid[0]` in the same cycle → `sync_valid[0]` = 1 and count stays 2. Repeat at count 4 → issue rejected, count becomes 3, `overflow_err[0]` set.
- **Timeout:** `TIMEOUT`=8, one issue to ch3, no return → `timeout_err[3]` rises exactly 8 cycles after the issue edge. A later return still pulses `sync_valid[3]`. `err_clr` clears the flag next cycle; a new error in the same cycle as `err_clr` keeps it set.
- **Spurious return:** `delayed_valid` = 4'b1111 with all channels idle → `sync_valid` = 0 and counts unchanged.
- **Async reset mid-flight:** ch0 and ch2 busy, `resetn` pulsed low between edges → `pend_busy` = 0 immediately; subsequent returns produce no pulses; new issues work normally.
